rc4_mem_sequencer: RTL and testbench
====================================

RC4_MEM_SEQUENCER -- requirements
Module: rc4_mem_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8192, max cycles allowed per client run before error.
REQ-002 SHALL have ports (clk and reset first):
  clk  in  1  sole clock, all state on rising edge
  reset  in  1  synchronous, active-high
  start  in  1  begin full init/shuffle/decrypt sequence
  abort  in  1  cancel sequence in progress
  secret_key  in  24  key, captured on accepted start
  key_out  out  24  latched key driven to clients
  init_start, shuf_start, dec_start  out  1 each  one-cycle client start pulses
  init_done, shuf_done, dec_done  in  1 each  client finish levels
  init_addr/shuf_addr/dec_addr  in  8 each  client S-memory address
  init_data/shuf_data/dec_data  in  8 each  client S-memory write data
  init_wen/shuf_wen/dec_wen  in  1 each  client S-memory write enable
  s_addr  out  8  S-memory address
  s_data  out  8  S-memory write data
  s_wen  out  1  S-memory write enable
  mem_sel  out  2  current owner of S-memory
  busy  out  1  sequence in progress
  done  out  1  sequence completed
  error  out  1  client timeout occurred

Function
REQ-003 FSM states SHALL be IDLE, INIT_START, INIT_RUN, SHUF_START, SHUF_RUN, DEC_START, DEC_RUN, DONE, ERROR.
REQ-004 In IDLE, DONE or ERROR, start=1 with abort=0 SHALL latch secret_key into key_out, clear done/error, and go to INIT_START next cycle.
REQ-005 start SHALL be ignored in all other states.
REQ-006 X_START states SHALL assert the matching x_start for exactly that one cycle, then go to X_RUN.
REQ-007 In X_RUN, x_done SHALL be ignored in the first RUN cycle; from the second cycle on, x_done=1 advances INIT_RUN->SHUF_START, SHUF_RUN->DEC_START, DEC_RUN->DONE.
REQ-008 A 16-bit run counter SHALL clear on entry to each X_RUN and increment each RUN cycle; reaching TIMEOUT_CYCLES without a qualified done SHALL go to ERROR.
REQ-009 abort=1 in any state other than IDLE/DONE/ERROR SHALL go to IDLE next cycle with no done and no error; abort SHALL win over a simultaneous done, timeout or start.
REQ-010 mem_sel encoding SHALL be 00 idle, 01 shuffle, 10 init, 11 decrypt; 10 in INIT_START/INIT_RUN, 01 in SHUF_*, 11 in DEC_*, 00 otherwise; mem_sel SHALL be registered.
REQ-011 s_addr/s_data/s_wen SHALL be a combinational mux of the client selected by mem_sel; when mem_sel=00 they SHALL be 0/0/0.
REQ-012 A non-selected client's wen SHALL never reach s_wen.
REQ-013 busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-014 done SHALL be 1 in DONE and remain so until the next accepted start or reset.
REQ-015 error SHALL be 1 in ERROR and remain so until the next accepted start or reset.
REQ-016 key_out SHALL hold stable between accepted starts.

Reset
REQ-017 reset SHALL override all inputs and force IDLE, mem_sel=00, all x_start=0, busy=0, done=0, error=0, key_out=0, run counter=0.
REQ-018 reset mid-sequence SHALL take effect on the next edge, with s_wen=0 from the following cycle.

Structure
REQ-019 A shared package SHALL hold the FSM state enum and the mem_sel constants SEL_IDLE, SEL_SHUFFLE, SEL_INIT, SEL_DECRYPT, for use by clients and the top level.
REQ-020 The S-memory mux SHALL be one sub-module, s_mem_mux, with mem_sel plus three client buses in and one memory bus out.

Verification
REQ-021 Bench SHALL cover these scenarios:
  Nominal run: key 24'h000249, start pulse, each client raises done 300 cycles after its start -> init_start, shuf_start, dec_start pulse once each in order; mem_sel 10->01->11->00; done=1; busy=0.
  Isolation: during SHUF_RUN, init_wen=1, shuf_wen=0 -> s_wen=0. With shuf_wen=1, shuf_addr=8'hAB -> s_wen=1, s_addr=8'hAB.
  Stale done: shuf_done held 1 from the previous run -> sequencer stays in SHUF_RUN until the client clears shuf_done and raises it again.
  Timeout: TIMEOUT_CYCLES=16, dec_done never asserted -> ERROR 16 cycles after DEC_RUN entry; error=1; mem_sel=00; a new start clears error.
  Abort: abort asserted in the same cycle as shuf_done -> IDLE next cycle; done=0; error=0; mem_sel=00.
  Reset mid-run: reset during INIT_RUN -> next cycle all outputs at reset values; start ignored while reset=1.

Source files
------------

// File: rtl/rc4_mem_sequencer_pkg.sv
// Shared types for the RC4 memory sequencer: FSM state enum and S-memory owner codes.
package rc4_mem_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT_START,
    INIT_RUN,
    SHUF_START,
    SHUF_RUN,
    DEC_START,
    DEC_RUN,
    DONE,
    ERROR
  } seq_state_t;

  localparam logic [1:0] SEL_IDLE    = 2'b00;
  localparam logic [1:0] SEL_SHUFFLE = 2'b01;
  localparam logic [1:0] SEL_INIT    = 2'b10;
  localparam logic [1:0] SEL_DECRYPT = 2'b11;

  function automatic logic [1:0] sel_for_state(input seq_state_t st);
    case (st)
      INIT_START, INIT_RUN: return SEL_INIT;
      SHUF_START, SHUF_RUN: return SEL_SHUFFLE;
      DEC_START, DEC_RUN:   return SEL_DECRYPT;
      default:              return SEL_IDLE;
    endcase
  endfunction

  function automatic logic is_busy(input seq_state_t st);
    return !(st inside {IDLE, DONE, ERROR});
  endfunction

endpackage

// File: rtl/rc4_mem_sequencer_s_mem_mux.sv
// S-memory port mux: forwards the bus of the client that currently owns the memory.
module s_mem_mux
  import rc4_mem_sequencer_pkg::*;
(
  input  logic [1:0] mem_sel,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_data,
  input  logic       init_wen,
  input  logic [7:0] shuf_addr,
  input  logic [7:0] shuf_data,
  input  logic       shuf_wen,
  input  logic [7:0] dec_addr,
  input  logic [7:0] dec_data,
  input  logic       dec_wen,
  output logic [7:0] s_addr,
  output logic [7:0] s_data,
  output logic       s_wen
);

  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wen  = 1'b0;
    case (mem_sel)
      SEL_INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wen  = init_wen;
      end
      SEL_SHUFFLE: begin
        s_addr = shuf_addr;
        s_data = shuf_data;
        s_wen  = shuf_wen;
      end
      SEL_DECRYPT: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wen  = dec_wen;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_mem_sequencer.sv
// Sequences the RC4 init, shuffle and decrypt clients over a shared S-memory,
// with per-run timeout and abort.
module rc4_mem_sequencer
  import rc4_mem_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] secret_key,
  output logic [23:0] key_out,
  output logic        init_start,
  output logic        shuf_start,
  output logic        dec_start,
  input  logic        init_done,
  input  logic        shuf_done,
  input  logic        dec_done,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  shuf_addr,
  input  logic [7:0]  dec_addr,
  input  logic [7:0]  init_data,
  input  logic [7:0]  shuf_data,
  input  logic [7:0]  dec_data,
  input  logic        init_wen,
  input  logic        shuf_wen,
  input  logic        dec_wen,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_data,
  output logic        s_wen,
  output logic [1:0]  mem_sel,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] RUN_LAST = 16'(TIMEOUT_CYCLES - 1);

  seq_state_t  state, state_next;
  logic [15:0] run_cnt;
  logic        armed;
  logic        client_done;
  logic        accept;
  logic        timeout;

  always_comb begin
    client_done = 1'b0;
    case (state)
      INIT_RUN: client_done = init_done;
      SHUF_RUN: client_done = shuf_done;
      DEC_RUN:  client_done = dec_done;
      default:  ;
    endcase
  end

  assign timeout = (run_cnt == RUN_LAST);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE, ERROR:
        if (start && !abort) begin
          state_next = INIT_START;
          accept     = 1'b1;
        end
      INIT_START: state_next = INIT_RUN;
      INIT_RUN:
        if (armed && client_done) state_next = SHUF_START;
        else if (timeout)         state_next = ERROR;
      SHUF_START: state_next = SHUF_RUN;
      SHUF_RUN:
        if (armed && client_done) state_next = DEC_START;
        else if (timeout)         state_next = ERROR;
      DEC_START: state_next = DEC_RUN;
      DEC_RUN:
        if (armed && client_done) state_next = DONE;
        else if (timeout)         state_next = ERROR;
      default: state_next = IDLE;
    endcase
    if (abort && is_busy(state)) state_next = IDLE;
  end

  // armed only after done is seen low inside the run, so a level left high
  // by the previous run (and the first run cycle) never counts as finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mem_sel <= SEL_IDLE;
      key_out <= '0;
      run_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= state_next;
      mem_sel <= sel_for_state(state_next);
      if (accept) key_out <= secret_key;
      if (state inside {INIT_RUN, SHUF_RUN, DEC_RUN}) begin
        run_cnt <= run_cnt + 16'd1;
        armed   <= armed | ~client_done;
      end else begin
        run_cnt <= '0;
        armed   <= 1'b0;
      end
    end
  end

  assign init_start = (state == INIT_START);
  assign shuf_start = (state == SHUF_START);
  assign dec_start  = (state == DEC_START);
  assign busy       = is_busy(state);
  assign done       = (state == DONE);
  assign error      = (state == ERROR);

  s_mem_mux u_mux (
    .mem_sel   (mem_sel),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_wen  (init_wen),
    .shuf_addr (shuf_addr),
    .shuf_data (shuf_data),
    .shuf_wen  (shuf_wen),
    .dec_addr  (dec_addr),
    .dec_data  (dec_data),
    .dec_wen   (dec_wen),
    .s_addr    (s_addr),
    .s_data    (s_data),
    .s_wen     (s_wen)
  );

endmodule

// File: tb/tb_rc4_mem_sequencer.sv
// Bench for rc4_mem_sequencer: instance 0 uses the default timeout, instance 1 a 16-cycle timeout.
module tb_rc4_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start [2];
  logic        abort [2];
  logic [23:0] secret_key [2];
  logic [23:0] key_out [2];
  logic        init_start [2], shuf_start [2], dec_start [2];
  logic        init_done [2], shuf_done [2], dec_done [2];
  logic [7:0]  init_addr [2], shuf_addr [2], dec_addr [2];
  logic [7:0]  init_data [2], shuf_data [2], dec_data [2];
  logic        init_wen [2], shuf_wen [2], dec_wen [2];
  logic [7:0]  s_addr [2], s_data [2];
  logic        s_wen [2];
  logic [1:0]  mem_sel [2];
  logic        busy [2], done [2], error [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rc4_mem_sequencer #(.TIMEOUT_CYCLES(g == 0 ? 8192 : 16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start[g]),
      .abort      (abort[g]),
      .secret_key (secret_key[g]),
      .key_out    (key_out[g]),
      .init_start (init_start[g]),
      .shuf_start (shuf_start[g]),
      .dec_start  (dec_start[g]),
      .init_done  (init_done[g]),
      .shuf_done  (shuf_done[g]),
      .dec_done   (dec_done[g]),
      .init_addr  (init_addr[g]),
      .shuf_addr  (shuf_addr[g]),
      .dec_addr   (dec_addr[g]),
      .init_data  (init_data[g]),
      .shuf_data  (shuf_data[g]),
      .dec_data   (dec_data[g]),
      .init_wen   (init_wen[g]),
      .shuf_wen   (shuf_wen[g]),
      .dec_wen    (dec_wen[g]),
      .s_addr     (s_addr[g]),
      .s_data     (s_data[g]),
      .s_wen      (s_wen[g]),
      .mem_sel    (mem_sel[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .error      (error[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cur_u  = 0;
  int cur_n  = 0;

  // client buses: index 0 = init, 1 = shuffle, 2 = decrypt
  logic [7:0] b_addr [3];
  logic [7:0] b_data [3];
  logic       b_wen  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u=%0d n=%0d observed=%0h expected=%0h", tag, cur_u, cur_n, obs, exp);
    end
  endtask

  task automatic randomize_buses();
    for (int k = 0; k < 3; k++) begin
      b_addr[k] = 8'($urandom);
      b_data[k] = 8'($urandom);
      b_wen[k]  = 1'($urandom);
    end
  endtask

  task automatic apply_buses(input int u);
    init_addr[u] = b_addr[0]; init_data[u] = b_data[0]; init_wen[u] = b_wen[0];
    shuf_addr[u] = b_addr[1]; shuf_data[u] = b_data[1]; shuf_wen[u] = b_wen[1];
    dec_addr[u]  = b_addr[2]; dec_data[u]  = b_data[2]; dec_wen[u]  = b_wen[2];
  endtask

  task automatic check_reset_state(input int u);
    cur_u = u;
    check("rst_init_start", init_start[u], 0);
    check("rst_shuf_start", shuf_start[u], 0);
    check("rst_dec_start",  dec_start[u],  0);
    check("rst_mem_sel",    mem_sel[u],    0);
    check("rst_busy",       busy[u],       0);
    check("rst_done",       done[u],       0);
    check("rst_error",      error[u],      0);
    check("rst_key_out",    key_out[u],    0);
    check("rst_s_wen",      s_wen[u],      0);
    check("rst_s_addr",     s_addr[u],     0);
    check("rst_s_data",     s_data[u],     0);
  endtask

  // One full sequence. lX = cycles after client X sees its start pulse before it
  // raises done (negative: never). Relative cycle 0 is the init_start cycle.
  task automatic run_seq(input int u, input logic [23:0] key, input int l1, input int l2,
                         input int l3, input int abort_at, input bit stale);
    int to, t2, t3, fin, sel_k;
    bit fin_done, fin_err;
    logic [1:0] exp_sel;
    to = (u == 0) ? 8192 : 16;
    t2 = 1 << 30;
    t3 = 1 << 30;
    fin_done = 1'b0;
    if (l1 < 0) fin = 1 + to;
    else begin
      t2 = l1 + 1;
      if (l2 < 0) fin = t2 + 1 + to;
      else begin
        t3 = t2 + l2 + 1;
        if (l3 < 0) fin = t3 + 1 + to;
        else begin
          fin = t3 + l3 + 1;
          fin_done = 1'b1;
        end
      end
    end
    if (abort_at >= 0 && abort_at + 1 <= fin) begin
      fin = abort_at + 1;
      fin_done = 1'b0;
      fin_err = 1'b0;
    end else begin
      fin_err = !fin_done;
    end

    cur_u = u;
    start[u] = 1'b1;
    abort[u] = 1'b0;
    secret_key[u] = key;
    @(posedge clk); #1;
    for (int n = 0; n <= fin + 2; n++) begin
      cur_n = n;
      init_done[u] = (l1 >= 0) && (n >= l1);
      if (n < t2) shuf_done[u] = stale;
      else shuf_done[u] = (l2 >= 0) && ((n >= t2 + l2) || (stale && n < t2 + 5));
      dec_done[u] = (l3 >= 0) && (n >= t3) && (n >= t3 + l3);
      abort[u] = (n == abort_at) || (n == fin);
      start[u] = (n < fin) ? 1'($urandom) : (n == fin);
      secret_key[u] = 24'($urandom);
      randomize_buses();
      if (n == t2 + 2 && n < t3 && n < fin) begin
        b_wen[0] = 1'b1;
        b_wen[1] = 1'b0;
      end
      if (n == t2 + 3 && n < t3 && n < fin) begin
        b_wen[1]  = 1'b1;
        b_addr[1] = 8'hAB;
      end
      apply_buses(u);
      exp_sel = (n >= fin) ? 2'b00 : (n < t2) ? 2'b10 : (n < t3) ? 2'b01 : 2'b11;
      case (exp_sel)
        2'b10:   sel_k = 0;
        2'b01:   sel_k = 1;
        2'b11:   sel_k = 2;
        default: sel_k = -1;
      endcase
      #1;
      check("init_start", init_start[u], n == 0);
      check("shuf_start", shuf_start[u], n == t2 && n < fin);
      check("dec_start",  dec_start[u],  n == t3 && n < fin);
      check("mem_sel",    mem_sel[u],    exp_sel);
      check("busy",       busy[u],       n < fin);
      check("done",       done[u],       fin_done && n >= fin);
      check("error",      error[u],      fin_err && n >= fin);
      check("key_out",    key_out[u],    key);
      check("s_addr", s_addr[u], (sel_k < 0) ? 8'h00 : b_addr[sel_k]);
      check("s_data", s_data[u], (sel_k < 0) ? 8'h00 : b_data[sel_k]);
      check("s_wen",  s_wen[u],  (sel_k < 0) ? 1'b0  : b_wen[sel_k]);
      if (n < fin + 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b1;
      abort[u] = 1'b0;
      secret_key[u] = 24'hFFFFFF;
      init_done[u] = 1'b0;
      shuf_done[u] = 1'b0;
      dec_done[u]  = 1'b0;
      for (int k = 0; k < 3; k++) begin
        b_addr[k] = 8'h5C;
        b_data[k] = 8'hC5;
        b_wen[k]  = 1'b1;
      end
      apply_buses(u);
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    reset = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    @(posedge clk); #1;

    // nominal run, 300-cycle clients
    run_seq(0, 24'h000249, 300, 300, 300, -1, 1'b0);

    // randomized complete runs on the short-timeout instance
    for (int r = 0; r < 4; r++)
      run_seq(1, 24'($urandom), $urandom_range(2, 14), $urandom_range(2, 14),
              $urandom_range(2, 14), -1, 1'b0);

    // stale shuffle done held high into the new run
    run_seq(1, 24'h13579B, 4, 10, 5, -1, 1'b1);

    // decrypt never finishes, then a new start clears error
    run_seq(1, 24'hC0FFEE, 3, 4, -1, -1, 1'b0);
    run_seq(1, 24'h2468AC, 5, 5, 5, -1, 1'b0);

    // init and shuffle timeouts
    run_seq(1, 24'h0F0F0F, -1, 3, 3, -1, 1'b0);
    run_seq(1, 24'hF0F0F0, 6, -1, 3, -1, 1'b0);

    // abort in the same cycle as shuf_done
    run_seq(1, 24'hABCDEF, 3, 6, 7, 10, 1'b0);

    // abort at a random point
    run_seq(1, 24'($urandom), $urandom_range(2, 14), $urandom_range(2, 14),
            $urandom_range(2, 14), $urandom_range(0, 30), 1'b0);

    // reset during INIT_RUN, with start held high under reset
    cur_u = 1;
    cur_n = -1;
    start[1] = 1'b1;
    abort[1] = 1'b0;
    secret_key[1] = 24'h5A5A5A;
    init_done[1] = 1'b0;
    @(posedge clk); #1;
    start[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_mem_sel", mem_sel[1], 2'b10);
    check("pre_rst_busy", busy[1], 1);
    reset = 1'b1;
    start[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_wen[k] = 1'b1;
      b_addr[k] = 8'h77;
    end
    apply_buses(1);
    @(posedge clk); #1;
    check_reset_state(1);
    @(posedge clk); #1;
    check_reset_state(1);
    reset = 1'b0;
    start[1] = 1'b0;
    @(posedge clk); #1;
    check_reset_state(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
